// File: rtl/arbitro_memoria_datos_if.sv
// Bus bundle between the two requesters, the arbiter and memoriaDatos.
// The master side drives requests and the memory's read data; the slave side is the arbiter.
interface arbitro_memoria_datos_if #(
  parameter int SIZE = 32
);
  logic            req0, req1;
  logic            we0, we1;
  logic            is_byte0, is_byte1;
  logic [SIZE-1:0] addr0, addr1;
  logic [SIZE-1:0] wdata0, wdata1;
  logic            ack0, ack1;
  logic            err0, err1;
  logic [SIZE-1:0] rdata0, rdata1;
  logic [SIZE-1:0] mem_address;
  logic [SIZE-1:0] mem_dato;
  logic            mem_MemWrite;
  logic            mem_MemRead;
  logic            mem_is_byte;
  logic [SIZE-1:0] mem_datoLeido;
  logic            busy;
  logic            grant_id;

  modport master (
    output req0, req1, we0, we1, is_byte0, is_byte1, addr0, addr1, wdata0, wdata1,
    output mem_datoLeido,
    input  ack0, ack1, err0, err1, rdata0, rdata1,
    input  mem_address, mem_dato, mem_MemWrite, mem_MemRead, mem_is_byte, busy, grant_id
  );

  modport slave (
    input  req0, req1, we0, we1, is_byte0, is_byte1, addr0, addr1, wdata0, wdata1,
    input  mem_datoLeido,
    output ack0, ack1, err0, err1, rdata0, rdata1,
    output mem_address, mem_dato, mem_MemWrite, mem_MemRead, mem_is_byte, busy, grant_id
  );
endinterface

// File: rtl/arbitro_memoria_datos.sv
// Two-port round-robin arbiter and access sequencer for memoriaDatos.
// IDLE -> ACCESS (WAIT_CYCLES) -> RESP -> IDLE; rejected accesses skip ACCESS.
module arbitro_memoria_datos #(
  parameter int          SIZE        = 32,
  parameter int unsigned SIZE_MEM    = 32'h7FF,
  parameter int          WAIT_CYCLES = 1,
  parameter int          CHECK_ALIGN = 1
) (
  input  logic clk,
  input  logic rst_n,
  arbitro_memoria_datos_if.slave bus
);
  localparam int NP = 2;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  typedef struct packed {
    logic            we;
    logic            is_byte;
    logic [SIZE-1:0] addr;
    logic [SIZE-1:0] wdata;
  } req_t;

  state_t                   state_q, state_d;
  req_t   [NP-1:0]          port_req;
  logic   [NP-1:0]          req_v;
  req_t                     cur_q;
  logic                     gnt_q, err_q, prio_q;
  logic   [CW-1:0]          cnt_q;
  logic   [NP-1:0][SIZE-1:0] rdata_q;
  logic                     sel, sel_err;
  req_t                     sel_req;
  logic   [NP-1:0]          ack_v, err_v;

  assign req_v       = {bus.req1, bus.req0};
  assign port_req[0] = '{we: bus.we0, is_byte: bus.is_byte0, addr: bus.addr0, wdata: bus.wdata0};
  assign port_req[1] = '{we: bus.we1, is_byte: bus.is_byte1, addr: bus.addr1, wdata: bus.wdata1};

  // The last addressed byte of a word must still lie below SIZE_MEM.
  function automatic logic access_err(req_t r);
    if (r.is_byte) return r.addr >= SIZE'(SIZE_MEM);
    return (r.addr >= SIZE'(SIZE_MEM - 3)) || ((CHECK_ALIGN != 0) && (r.addr[1:0] != 2'b00));
  endfunction

  always_comb begin
    sel     = (req_v == 2'b11) ? prio_q : req_v[1];
    sel_req = port_req[sel];
    sel_err = access_err(sel_req);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req_v) state_d = sel_err ? RESP : ACCESS;
      ACCESS:  if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_q   <= '0;
      gnt_q   <= 1'b0;
      err_q   <= 1'b0;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (|req_v) begin
          cur_q <= sel_req;
          gnt_q <= sel;
          err_q <= sel_err;
          cnt_q <= CW'(WAIT_CYCLES - 1);
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            for (int i = 0; i < NP; i++)
              if (!cur_q.we && gnt_q == 1'(i)) rdata_q[i] <= bus.mem_datoLeido;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP:    prio_q <= ~gnt_q;
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NP; i++) begin : g_port
    assign ack_v[i] = (state_q == RESP) && (gnt_q == 1'(i));
    assign err_v[i] = ack_v[i] && err_q;
  end

  assign bus.ack0   = ack_v[0];
  assign bus.ack1   = ack_v[1];
  assign bus.err0   = err_v[0];
  assign bus.err1   = err_v[1];
  assign bus.rdata0 = rdata_q[0];
  assign bus.rdata1 = rdata_q[1];

  // The counter sits at its load value only in the first ACCESS cycle, so a store writes once.
  always_comb begin
    bus.mem_address  = '0;
    bus.mem_dato     = '0;
    bus.mem_is_byte  = 1'b0;
    bus.mem_MemRead  = 1'b0;
    bus.mem_MemWrite = 1'b0;
    bus.busy         = (state_q != IDLE);
    bus.grant_id     = (state_q != IDLE) ? gnt_q : 1'b0;
    if (state_q == ACCESS) begin
      bus.mem_address  = cur_q.addr;
      bus.mem_dato     = cur_q.wdata;
      bus.mem_is_byte  = cur_q.is_byte;
      bus.mem_MemRead  = ~cur_q.we;
      bus.mem_MemWrite = cur_q.we && (cnt_q == CW'(WAIT_CYCLES - 1));
    end
  end
endmodule

// File: tb/tb_arbitro_memoria_datos.sv
// Randomized scoreboard bench for arbitro_memoria_datos: a byte-array memory reference
// predicts each ack; a second instance with WAIT_CYCLES=3 covers reset mid-access.
module tb_arbitro_memoria_datos;
  logic clk = 1'b0;
  logic rst_n, rst_b;
  always #5 clk = ~clk;

  arbitro_memoria_datos_if #(.SIZE(32)) a_if ();
  arbitro_memoria_datos_if #(.SIZE(32)) b_if ();

  arbitro_memoria_datos #(.SIZE(32), .SIZE_MEM(32'h7FF), .WAIT_CYCLES(1), .CHECK_ALIGN(1))
    dut (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  arbitro_memoria_datos #(.SIZE(32), .SIZE_MEM(32'h7FF), .WAIT_CYCLES(3), .CHECK_ALIGN(1))
    dut_w3 (.clk(clk), .rst_n(rst_b), .bus(b_if.slave));

  typedef struct packed {
    logic        we;
    logic        is_byte;
    logic [31:0] addr;
    logic [31:0] wdata;
  } op_t;

  typedef struct {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sbq[$];
  logic [7:0]  dmem    [0:2047];
  logic [7:0]  ref_mem [0:2047];
  logic [31:0] held    [2];
  int   last_port;
  int   mw_a = 0, mr_a = 0, mw_b = 0, mr_b = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // memoriaDatos stand-in: big-endian bytes, write on the edge, combinational read.
  always @(posedge clk) begin
    if (a_if.mem_MemWrite) begin
      if (a_if.mem_is_byte) dmem[a_if.mem_address[10:0]] <= a_if.mem_dato[31:24];
      else begin
        dmem[a_if.mem_address[10:0]]        <= a_if.mem_dato[31:24];
        dmem[a_if.mem_address[10:0] + 11'd1] <= a_if.mem_dato[23:16];
        dmem[a_if.mem_address[10:0] + 11'd2] <= a_if.mem_dato[15:8];
        dmem[a_if.mem_address[10:0] + 11'd3] <= a_if.mem_dato[7:0];
      end
    end
  end

  always_comb begin
    logic [10:0] a;
    a = a_if.mem_address[10:0];
    if (!a_if.mem_MemRead)   a_if.mem_datoLeido = 32'h0;
    else if (a_if.mem_is_byte) a_if.mem_datoLeido = {24'h0, dmem[a]};
    else a_if.mem_datoLeido = {dmem[a], dmem[a + 11'd1], dmem[a + 11'd2], dmem[a + 11'd3]};
  end

  always_comb b_if.mem_datoLeido = b_if.mem_MemRead ? (32'hC0DE0000 | b_if.mem_address) : 32'h0;

  always @(negedge clk) begin
    if (a_if.mem_MemWrite) mw_a++;
    if (a_if.mem_MemRead)  mr_a++;
    if (b_if.mem_MemWrite) mw_b++;
    if (b_if.mem_MemRead)  mr_b++;
  end

  // Monitor: every ack pops the oldest prediction.
  always @(negedge clk) begin : mon
    exp_t e;
    logic p;
    if (a_if.ack0 || a_if.ack1) begin
      chk("ack_onehot", {31'h0, a_if.ack0 & a_if.ack1}, 32'h0);
      p = a_if.ack1;
      if (sbq.size() == 0) chk("unexpected_ack", 32'h1, 32'h0);
      else begin
        e = sbq.pop_front();
        chk("ack_port", {31'h0, p}, {31'h0, e.port});
        chk("err", {31'h0, p ? a_if.err1 : a_if.err0}, {31'h0, e.err});
        chk("err_other", {31'h0, p ? a_if.err0 : a_if.err1}, 32'h0);
        chk("rdata", p ? a_if.rdata1 : a_if.rdata0, e.rdata);
      end
    end
  end

  function automatic logic ref_err(op_t o);
    if (o.is_byte) return o.addr > 32'h7FE;
    return (o.addr + 32'd3 > 32'h7FE) || (o.addr % 4 != 0);
  endfunction

  task automatic predict(input int p, input op_t o);
    exp_t e;
    int   a;
    e.port = 1'(p);
    e.err  = ref_err(o);
    a = int'(o.addr[10:0]);
    if (!e.err) begin
      if (o.we) begin
        if (o.is_byte) ref_mem[a] = o.wdata[31:24];
        else for (int k = 0; k < 4; k++) ref_mem[a + k] = o.wdata[31 - 8*k -: 8];
      end else begin
        held[p] = o.is_byte ? {24'h0, ref_mem[a]}
                            : {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
      end
    end
    e.rdata = held[p];
    sbq.push_back(e);
    last_port = p;
  endtask

  function automatic op_t mk(input logic we, input logic b, input logic [31:0] a, input logic [31:0] d);
    op_t o;
    o.we = we; o.is_byte = b; o.addr = a; o.wdata = d;
    return o;
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    o.we      = 1'($urandom_range(0, 1));
    o.is_byte = 1'($urandom_range(0, 1));
    o.wdata   = $urandom;
    case ($urandom_range(0, 3))
      0:       o.addr = 32'($urandom_range(0, 15)) << 2;
      1:       o.addr = 32'($urandom_range(0, 63));
      2:       o.addr = 32'($urandom_range(32'h7F0, 32'h7FF));
      default: o.addr = $urandom;
    endcase
    return o;
  endfunction

  // Holds each req until its ack; lat is cycles from the request edge to the first ack.
  task automatic issue(input logic [1:0] mask, input op_t o0, input op_t o1, output int lat);
    logic [1:0] pend;
    int n;
    @(negedge clk);
    a_if.we0 = o0.we; a_if.is_byte0 = o0.is_byte; a_if.addr0 = o0.addr; a_if.wdata0 = o0.wdata;
    a_if.we1 = o1.we; a_if.is_byte1 = o1.is_byte; a_if.addr1 = o1.addr; a_if.wdata1 = o1.wdata;
    a_if.req0 = mask[0];
    a_if.req1 = mask[1];
    if (mask == 2'b11) begin
      if (last_port == 0) begin predict(1, o1); predict(0, o0); end
      else begin predict(0, o0); predict(1, o1); end
    end else if (mask[0]) predict(0, o0);
    else if (mask[1])     predict(1, o1);
    pend = mask; n = 0; lat = -1;
    while (pend != 2'b00 && n < 40) begin
      @(posedge clk); n++; @(negedge clk);
      if (a_if.ack0 && pend[0]) begin pend[0] = 1'b0; a_if.req0 = 1'b0; if (lat < 0) lat = n; end
      if (a_if.ack1 && pend[1]) begin pend[1] = 1'b0; a_if.req1 = 1'b0; if (lat < 0) lat = n; end
    end
    if (pend != 2'b00) chk("ack_timeout", {30'h0, pend}, 32'h0);
  endtask

  task automatic wait_b(output logic p, output int lat);
    lat = -1; p = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); @(negedge clk);
      if (b_if.ack0 || b_if.ack1) begin p = b_if.ack1; lat = n; break; end
    end
    if (lat < 0) chk("b_timeout", 32'h1, 32'h0);
  endtask

  initial begin
    int   lat, m0, m1, acks;
    logic p;
    logic [1:0] mask;
    op_t  o0, o1;
    for (int i = 0; i < 2048; i++) begin dmem[i] = 8'h0; ref_mem[i] = 8'h0; end
    held[0] = 32'h0; held[1] = 32'h0; last_port = 1;
    {b_if.req0, b_if.req1, b_if.we0, b_if.we1, b_if.is_byte0, b_if.is_byte1} = '0;
    {b_if.addr0, b_if.addr1, b_if.wdata0, b_if.wdata1} = '0;
    {a_if.we0, a_if.we1, a_if.is_byte0, a_if.is_byte1} = '0;
    a_if.addr0 = 32'h0; a_if.addr1 = 32'h4; a_if.wdata0 = '0; a_if.wdata1 = '0;
    rst_n = 1'b0; rst_b = 1'b0;
    a_if.req0 = 1'b1; a_if.req1 = 1'b1;

    // Reset with both requests high.
    repeat (3) @(negedge clk);
    chk("rst_ack", {30'h0, a_if.ack1, a_if.ack0}, 32'h0);
    chk("rst_busy", {31'h0, a_if.busy}, 32'h0);
    chk("rst_grant", {31'h0, a_if.grant_id}, 32'h0);
    chk("rst_strobes", {30'h0, a_if.mem_MemRead, a_if.mem_MemWrite}, 32'h0);
    chk("rst_addr", a_if.mem_address | a_if.mem_dato, 32'h0);
    chk("rst_rdata", a_if.rdata0 | a_if.rdata1, 32'h0);
    rst_n = 1'b1; rst_b = 1'b1;
    issue(2'b11, mk(0, 0, 32'h0, 0), mk(0, 0, 32'h4, 0), lat);

    // Word store then load back, WAIT_CYCLES=1.
    m0 = mw_a;
    issue(2'b01, mk(1, 0, 32'h10, 32'hDEADBEEF), '0, lat);
    chk("sw_lat", lat, 2);
    chk("sw_single_write", mw_a - m0, 1);
    issue(2'b01, mk(0, 0, 32'h10, 0), '0, lat);
    chk("lw_lat", lat, 2);
    chk("lw_rdata0", a_if.rdata0, 32'hDEADBEEF);

    // Both held: grants must alternate.
    issue(2'b11, mk(0, 0, 32'h10, 0), mk(1, 0, 32'h14, 32'h12345678), lat);
    issue(2'b11, mk(0, 0, 32'h14, 0), mk(0, 0, 32'h10, 0), lat);

    // Range boundaries.
    m1 = mr_a;
    issue(2'b10, '0, mk(0, 0, 32'h7FC, 0), lat);
    chk("oob_word_lat", lat, 1);
    chk("oob_no_read", mr_a - m1, 0);
    issue(2'b10, '0, mk(0, 1, 32'h7FE, 0), lat);
    chk("lb_top_lat", lat, 2);
    issue(2'b10, '0, mk(0, 1, 32'h7FF, 0), lat);
    chk("oob_byte_lat", lat, 1);
    issue(2'b10, '0, mk(0, 0, 32'h7F8, 0), lat);
    chk("lw_top_lat", lat, 2);

    // Byte store/load and misalignment.
    issue(2'b01, mk(1, 1, 32'h21, 32'hAB000000), '0, lat);
    issue(2'b01, mk(0, 1, 32'h21, 0), '0, lat);
    chk("lb_rdata0", a_if.rdata0, 32'h000000AB);
    issue(2'b01, mk(0, 0, 32'h22, 0), '0, lat);
    chk("misalign_lat", lat, 1);

    for (int it = 0; it < 150; it++) begin
      mask = 2'($urandom_range(1, 3));
      o0 = rnd_op(); o1 = rnd_op();
      issue(mask, o0, o1, lat);
      if (mask == 2'b01) chk("rnd_lat0", lat, ref_err(o0) ? 1 : 2);
      if (mask == 2'b10) chk("rnd_lat1", lat, ref_err(o1) ? 1 : 2);
    end
    repeat (2) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);

    // WAIT_CYCLES=3 instance: single write, latency, then reset mid-ACCESS.
    @(negedge clk);
    b_if.we1 = 1'b1; b_if.addr1 = 32'h8; b_if.wdata1 = 32'h11223344; b_if.req1 = 1'b1;
    m0 = mw_b; m1 = mr_b;
    wait_b(p, lat); b_if.req1 = 1'b0;
    chk("b_sw_lat", lat, 4);
    chk("b_sw_single_write", mw_b - m0, 1);
    chk("b_sw_no_read", mr_b - m1, 0);
    @(negedge clk);
    b_if.we0 = 1'b0; b_if.addr0 = 32'h10; b_if.req0 = 1'b1;
    wait_b(p, lat); b_if.req0 = 1'b0;
    chk("b_lw_lat", lat, 4);
    chk("b_lw_port", {31'h0, p}, 32'h0);
    chk("b_lw_rdata0", b_if.rdata0, 32'hC0DE0010);
    @(negedge clk);
    b_if.we1 = 1'b0; b_if.addr1 = 32'h20; b_if.req1 = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("b_busy", {31'h0, b_if.busy}, 32'h1);
    chk("b_grant", {31'h0, b_if.grant_id}, 32'h1);
    @(posedge clk); @(negedge clk);
    chk("b_read_strobe", {31'h0, b_if.mem_MemRead}, 32'h1);
    rst_b = 1'b0; b_if.req1 = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("b_rst_busy", {31'h0, b_if.busy}, 32'h0);
    chk("b_rst_grant", {31'h0, b_if.grant_id}, 32'h0);
    chk("b_rst_strobe", {31'h0, b_if.mem_MemRead}, 32'h0);
    chk("b_rst_rdata", b_if.rdata0, 32'h0);
    rst_b = 1'b1;
    acks = 0;
    repeat (6) begin
      @(posedge clk); @(negedge clk);
      if (b_if.ack0 || b_if.ack1) acks++;
    end
    chk("b_no_ack_after_rst", acks, 0);
    b_if.addr0 = 32'h30; b_if.addr1 = 32'h40; b_if.req0 = 1'b1; b_if.req1 = 1'b1;
    wait_b(p, lat); b_if.req0 = 1'b0;
    chk("b_prio_reset", {31'h0, p}, 32'h0);
    chk("b_first_lat", lat, 4);
    wait_b(p, lat); b_if.req1 = 1'b0;
    chk("b_second_port", {31'h0, p}, 32'h1);
    chk("b_spacing", lat, 5);
    chk("b_rdata1", b_if.rdata1, 32'hC0DE0040);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
